flow_control: RTL and testbench

FLOW_CONTROL -- requirements
Module: flow_control

---
 rtl/flow_control_pkg.sv | 15 +
 rtl/flow_control_elem_select.sv | 36 +++
 rtl/flow_control.sv | 135 +++++++++++++
 tb/tb_flow_control.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/flow_control_pkg.sv
// flow_control_pkg: shared default widths, tag/index widths and FSM state encoding
package flow_control_pkg;

    localparam int I_BW_DEF = 14;
    localparam int O_BW_DEF = 14;
    localparam int N_CH_DEF = 64;
    localparam int TAG_W    = 7;
    localparam int GIDX_W   = 6;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } state_e;

endpackage

// File: rtl/flow_control_elem_select.sv
// elem_select: picks one element of a packed vector and fits it to the output width
module elem_select
    import flow_control_pkg::*;
#(
    parameter int I_BW = I_BW_DEF,
    parameter int O_BW = O_BW_DEF,
    parameter int N_CH = N_CH_DEF,
    localparam int IW  = $clog2(N_CH)
) (
    input  logic signed [I_BW*N_CH-1:0] vec_i,
    input  logic        [IW-1:0]        idx_i,
    output logic signed [O_BW-1:0]      val_o
);

    logic signed [I_BW-1:0] elems [N_CH];
    logic signed [I_BW-1:0] elem;

    for (genvar g = 0; g < N_CH; g++) begin : g_unpack
        assign elems[g] = vec_i[g*I_BW +: I_BW];
    end

    assign elem = elems[idx_i];

    if (O_BW > I_BW) begin : g_ext
        assign val_o = {{(O_BW-I_BW){elem[I_BW-1]}}, elem};
    end else if (O_BW == I_BW) begin : g_pass
        assign val_o = elem;
    end else begin : g_sat
        // Clamp to the signed O_BW range; MIN is the bitwise complement of MAX.
        localparam logic signed [I_BW-1:0] MAX = I_BW'((64'sd1 <<< (O_BW-1)) - 64'sd1);
        localparam logic signed [I_BW-1:0] MIN = ~MAX;
        assign val_o = (elem > MAX) ? MAX[O_BW-1:0] :
                       (elem < MIN) ? MIN[O_BW-1:0] : elem[O_BW-1:0];
    end

endmodule

// File: rtl/flow_control.sv
// flow_control: captures wide vectors on a strobe and serializes them one element per cycle
module flow_control
    import flow_control_pkg::*;
#(
    parameter int I_BW = I_BW_DEF,
    parameter int O_BW = O_BW_DEF,
    parameter int N_CH = N_CH_DEF
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        di_en,
    input  logic signed [I_BW*N_CH-1:0] data_i,
    input  logic        [TAG_W-1:0]     in_group_num,
    output logic                        do_en,
    output logic signed [O_BW-1:0]      data_o,
    output logic        [GIDX_W-1:0]    out_group_idx,
    output logic        [TAG_W-1:0]     out_group_num
);

    localparam int IW = $clog2(N_CH);
    localparam logic [IW-1:0] LAST = IW'(N_CH-1);

    state_e                      state_q, state_d;
    logic        [IW-1:0]        idx_q, idx_d;
    logic signed [I_BW*N_CH-1:0] act_q, act_d;
    logic        [TAG_W-1:0]     act_tag_q, act_tag_d;
    logic signed [I_BW*N_CH-1:0] pend_q, pend_d;
    logic        [TAG_W-1:0]     pend_tag_q, pend_tag_d;
    logic                        pend_vld_q, pend_vld_d;
    logic                        do_en_q, do_en_d;
    logic signed [O_BW-1:0]      data_q, data_d;
    logic        [GIDX_W-1:0]    oidx_q, oidx_d;
    logic        [TAG_W-1:0]     otag_q, otag_d;
    logic signed [O_BW-1:0]      sel;

    elem_select #(
        .I_BW (I_BW),
        .O_BW (O_BW),
        .N_CH (N_CH)
    ) u_sel (
        .vec_i (act_q),
        .idx_i (idx_q),
        .val_o (sel)
    );

    // Next state: IDLE waits for a strobe; STREAM walks the index and swaps slots at the last one.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        act_d      = act_q;
        act_tag_d  = act_tag_q;
        pend_d     = pend_q;
        pend_tag_d = pend_tag_q;
        pend_vld_d = pend_vld_q;
        if (state_q == ST_IDLE) begin
            if (di_en) begin
                state_d   = ST_STREAM;
                idx_d     = '0;
                act_d     = data_i;
                act_tag_d = in_group_num;
            end
        end else begin
            if (di_en) begin
                pend_d     = data_i;
                pend_tag_d = in_group_num;
            end
            if (idx_q != LAST) begin
                idx_d      = idx_q + 1'b1;
                pend_vld_d = pend_vld_q | di_en;
            end else begin
                idx_d = '0;
                if (pend_vld_q) begin
                    act_d      = pend_q;
                    act_tag_d  = pend_tag_q;
                    pend_vld_d = di_en;
                end else if (di_en) begin
                    act_d     = data_i;
                    act_tag_d = in_group_num;
                end else begin
                    state_d = ST_IDLE;
                end
            end
        end
    end

    // Output stage: registered view of the current element, all zero while idle.
    always_comb begin
        do_en_d = (state_q == ST_STREAM);
        data_d  = do_en_d ? sel : '0;
        oidx_d  = do_en_d ? GIDX_W'(idx_q) : '0;
        otag_d  = do_en_d ? act_tag_q : '0;
    end

    // Control and slot registers; reset drops any group in flight and any pending vector.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            act_q      <= '0;
            act_tag_q  <= '0;
            pend_q     <= '0;
            pend_tag_q <= '0;
            pend_vld_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            act_q      <= act_d;
            act_tag_q  <= act_tag_d;
            pend_q     <= pend_d;
            pend_tag_q <= pend_tag_d;
            pend_vld_q <= pend_vld_d;
        end
    end

    // Output registers, cleared asynchronously so a reset blanks the outputs at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            do_en_q <= 1'b0;
            data_q  <= '0;
            oidx_q  <= '0;
            otag_q  <= '0;
        end else begin
            do_en_q <= do_en_d;
            data_q  <= data_d;
            oidx_q  <= oidx_d;
            otag_q  <= otag_d;
        end
    end

    assign do_en         = do_en_q;
    assign data_o        = data_q;
    assign out_group_idx = oidx_q;
    assign out_group_num = otag_q;

endmodule

// File: tb/tb_flow_control.sv
// tb_flow_control: directed table and sequence checks of the vector serializer
module tb_flow_control;

    localparam int I_BW = 14;
    localparam int O_BW = 14;
    localparam int N_CH = 64;

    logic                        clk = 1'b0;
    logic                        rst = 1'b1;
    logic                        di_en = 1'b0;
    logic signed [I_BW*N_CH-1:0] data_i = '0;
    logic        [6:0]           in_group_num = '0;
    logic                        do_en;
    logic signed [O_BW-1:0]      data_o;
    logic        [5:0]           out_group_idx;
    logic        [6:0]           out_group_num;

    int n_tests = 0;
    int n_fail  = 0;
    logic signed [I_BW-1:0] vec [N_CH];

    typedef struct {
        int tag;
        int e0;
        int e31;
        int e63;
        int x0;
        int x31;
        int x63;
    } vec_t;
    vec_t tbl [4];

    flow_control #(
        .I_BW (I_BW),
        .O_BW (O_BW),
        .N_CH (N_CH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .di_en         (di_en),
        .data_i        (data_i),
        .in_group_num  (in_group_num),
        .do_en         (do_en),
        .data_o        (data_o),
        .out_group_idx (out_group_idx),
        .out_group_num (out_group_num)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_ramp(input int base);
        for (int k = 0; k < N_CH; k++) vec[k] = I_BW'(base + k);
    endtask

    task automatic pulse(input int tag);
        for (int k = 0; k < N_CH; k++) data_i[k*I_BW +: I_BW] = vec[k];
        in_group_num = 7'(tag);
        di_en = 1'b1;
        step();
        di_en = 1'b0;
    endtask

    task automatic out_chk(input string nm, input int idx, input int tag, input int val);
        step();
        chk({nm, ".en"}, do_en, 1);
        chk({nm, ".idx"}, out_group_idx, idx);
        chk({nm, ".tag"}, out_group_num, tag);
        chk({nm, ".data"}, data_o, val);
    endtask

    task automatic burst(input string nm, input int tag, input int base);
        for (int i = 0; i < N_CH; i++) out_chk(nm, i, tag, base + i);
    endtask

    task automatic zero_chk(input string nm);
        chk({nm, ".en"}, do_en, 0);
        chk({nm, ".data"}, data_o, 0);
        chk({nm, ".idx"}, out_group_idx, 0);
        chk({nm, ".tag"}, out_group_num, 0);
    endtask

    task automatic idle_chk(input string nm);
        step();
        zero_chk(nm);
    endtask

    initial begin
        tbl[0] = '{tag: 5,   e0: -8192, e31: 0,     e63: 8191,  x0: -8192, x31: 0,     x63: 8191};
        tbl[1] = '{tag: 127, e0: -1,    e31: 1,     e63: -8191, x0: -1,    x31: 1,     x63: -8191};
        tbl[2] = '{tag: 0,   e0: 8191,  e31: -8192, e63: 0,     x0: 8191,  x31: -8192, x63: 0};
        tbl[3] = '{tag: 64,  e0: 100,   e31: -100,  e63: -2,    x0: 100,   x31: -100,  x63: -2};

        #1;
        zero_chk("reset");
        step();
        step();
        rst = 1'b0;

        // single group, tag 5, elements 100..163
        load_ramp(100);
        pulse(5);
        chk("single.lat", do_en, 0);
        burst("single", 5, 100);
        idle_chk("single.end");

        // periodic strobes every 513 cycles
        for (int g = 0; g < 3; g++) begin
            load_ramp(300 + 100 * g);
            pulse(g);
            chk("periodic.lat", do_en, 0);
            burst("periodic", g, 300 + 100 * g);
            idle_chk("periodic.end");
            repeat (447) step();
            chk("periodic.gap", do_en, 0);
        end

        // table: sign boundaries and tag extremes
        for (int t = 0; t < 4; t++) begin
            load_ramp(0);
            vec[0]  = I_BW'(tbl[t].e0);
            vec[31] = I_BW'(tbl[t].e31);
            vec[63] = I_BW'(tbl[t].e63);
            pulse(tbl[t].tag);
            for (int i = 0; i < N_CH; i++) begin
                step();
                chk("tbl.en", do_en, 1);
                chk("tbl.idx", out_group_idx, i);
                chk("tbl.tag", out_group_num, tbl[t].tag);
                if (i == 0) chk("tbl.d0", data_o, tbl[t].x0);
                if (i == 31) chk("tbl.d31", data_o, tbl[t].x31);
                if (i == 63) chk("tbl.d63", data_o, tbl[t].x63);
            end
            idle_chk("tbl.end");
        end

        // back-to-back: second strobe 10 cycles after the first
        fork
            begin
                load_ramp(200);
                pulse(1);
                repeat (9) step();
                load_ramp(1200);
                pulse(2);
            end
            begin
                step();
                burst("b2b.a", 1, 200);
                burst("b2b.b", 2, 1200);
                idle_chk("b2b.end");
            end
        join

        // pending overwrite: tag 2 replaced by tag 3 before it is used
        fork
            begin
                load_ramp(10);
                pulse(1);
                repeat (4) step();
                load_ramp(2000);
                pulse(2);
                step();
                load_ramp(3000);
                pulse(3);
            end
            begin
                step();
                burst("ovw.a", 1, 10);
                burst("ovw.c", 3, 3000);
                idle_chk("ovw.end");
            end
        join

        // strobe coinciding with the last element while nothing is pending
        fork
            begin
                load_ramp(400);
                pulse(6);
                repeat (63) step();
                load_ramp(-500);
                pulse(7);
            end
            begin
                step();
                burst("last.a", 6, 400);
                burst("last.b", 7, -500);
                idle_chk("last.end");
            end
        join

        // reset mid-group, with a vector pending
        load_ramp(1000);
        pulse(9);
        for (int i = 0; i <= 20; i++) begin
            if (i == 10) begin
                load_ramp(4000);
                for (int k = 0; k < N_CH; k++) data_i[k*I_BW +: I_BW] = vec[k];
                in_group_num = 7'd10;
                di_en = 1'b1;
            end
            out_chk("rstmid", i, 9, 1000 + i);
            di_en = 1'b0;
        end
        rst = 1'b1;
        #1;
        zero_chk("rstmid.async");
        di_en = 1'b1;
        step();
        step();
        chk("rstmid.hold", do_en, 0);
        rst = 1'b0;
        di_en = 1'b0;
        for (int i = 0; i < 70; i++) begin
            step();
            chk("rstmid.after", do_en, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
